// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX sides: FSM state encoding,
// default frame width and the baud divisor derived from CLK_HZ/BAUD.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_CLK_HZ     = 100_000_000;
  localparam int UART_BAUD       = 115_200;

  // Rounded to the nearest whole clock: 100 MHz / 115200 -> 868.
  localparam int UART_BAUD_DIV_DERIVED = (UART_CLK_HZ + UART_BAUD / 2) / UART_BAUD;
  localparam int UART_BAUD_DIV_DEFAULT = UART_BAUD_DIV_DERIVED;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and status between the UART register block (master)
// and the TX serializer (slave).
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) ();

  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last clock of
// each bit with bit_end; clr holds it at zero between frames.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = !clr && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional even
// parity (define UART_TX_PARITY_EN), one stop bit; registered serial output.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int BAUD_DIV   = UART_BAUD_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_serializer_if.slave   bus,
  output logic                  tx_serial
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state, state_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic                  serial_d;
  logic                  clr;
  logic                  bit_end;
  logic                  done;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bit_end (bit_end)
  );

  assign bus.tx_ready = (state == ST_IDLE);
  assign bus.tx_busy  = (state != ST_IDLE);
  assign bus.tx_done  = done;

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    idx_d    = idx;
    serial_d = 1'b1;
    clr      = 1'b0;
    done     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state)
      ST_IDLE: begin
        // Counter held at zero so START gets a full bit period.
        clr = 1'b1;
        if (bus.tx_valid) begin
          shreg_d = bus.tx_data;
          idx_d   = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(bus.tx_data);
`endif
        end
      end
      ST_START: begin
        serial_d = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        serial_d = shreg[0];
        if (bit_end) begin
          shreg_d = shreg >> 1;
          idx_d   = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        serial_d = par_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line is registered from the current state, so it trails the FSM by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      idx       <= '0;
      tx_serial <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      idx       <= idx_d;
      tx_serial <= serial_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmitter; the transmit-side counterpart of the MIPS_UART receive shift path. It accepts a parallel byte over a valid/ready handshake and frames it as start bit, DATA_WIDTH data bits (LSB first), optional parity and one stop bit. It drives the serial line at CLK/BAUD_DIV and sits between the MIPS UART register interface and the TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9).
BAUD_DIV, 868, clocks per bit (100 MHz / 115200); legal range 2..65535.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
tx_valid  input  1  tx_data is valid; a transfer occurs when tx_valid && tx_ready.
tx_data  input  DATA_WIDTH  byte to transmit; sampled only on the transfer cycle.
tx_ready  output  1  high only in IDLE; the block can accept a byte.
tx_busy  output  1  high from the cycle after the transfer until the end of the stop bit.
tx_done  output  1  one-cycle pulse on the last clock of the stop bit.
tx_serial  output  1  registered serial line; idles high.

Behaviour:
- Reset (async): tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0, shift register=0. Reset mid-frame aborts the frame and returns the line high immediately.
- FSM states: IDLE, START, DATA, PARITY (only with the feature enabled), STOP.
- IDLE: tx_serial=1. On transfer, load the shift register with tx_data, clear the baud counter and bit index, and go to START.
- Bit timing: the baud counter counts 0..BAUD_DIV-1 within each state. A bit ends when the counter reaches BAUD_DIV-1 (the bit_end strobe); the counter then wraps to 0.
- START: tx_serial=0 for BAUD_DIV clocks. On bit_end, go to DATA.
- DATA: tx_serial = shift register bit 0. On each bit_end, right-shift the register (zero fill) and increment the bit index. After DATA_WIDTH bits, go to PARITY if enabled, otherwise STOP.
- STOP: tx_serial=1 for BAUD_DIV clocks. On bit_end, pulse tx_done and go to IDLE.
- Latency: tx_serial falls on the first clock edge after the transfer edge. Frame length is (DATA_WIDTH+2)*BAUD_DIV clocks, or (DATA_WIDTH+3)*BAUD_DIV with parity.
- Back-to-back: tx_ready rises in the cycle after the tx_done pulse. If tx_valid is held high, the next start bit begins one clock later, giving a 1-clock extra idle between frames.
- tx_valid while busy is ignored; no buffering. tx_data changes outside the transfer cycle have no effect.
- tx_busy = (state != IDLE). tx_done never asserts together with tx_ready.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state of BAUD_DIV clocks between DATA and STOP. tx_serial = XOR of the latched data (even parity). The parity value is computed at load time and stored in a register.
- Undefined: no PARITY state, no parity register, frame is 8N1.

Decomposition:
- Shared package uart_pkg: FSM state encoding constants, default DATA_WIDTH, default BAUD_DIV, and the CLK_HZ/BAUD-derived divisor constant. The package is shared with the RX side.
- One natural sub-module: uart_baud_tick. It is a BAUD_DIV counter with a synchronous clear, outputs bit_end, and resets asynchronously on rst.

Test Plan:
- BAUD_DIV=4, send 0xA5 -> tx_serial: 0 x4 clks, then 1,0,1,0,0,1,0,1 each x4 clks, then 1 x4 clks. tx_done pulses once at clock 40 after the transfer; tx_busy is high for 40 clocks.
- Reset asserted at clock 13 of a 0xFF frame -> tx_serial=1, tx_ready=1, tx_busy=0 immediately. A subsequent 0x00 frame transmits correctly.
- tx_valid held high with 0x55 then 0x0F -> two complete frames. The start bit of the second frame begins 1 clock after tx_done of the first.
- tx_valid pulsed with 0x33 while busy sending 0x81 -> 0x33 ignored; only 0x81 appears on the line; tx_ready stays low throughout.
- UART_TX_PARITY_EN with 0xA5 -> parity bit 0. With 0x07 -> parity bit 1. Frame length is 44 clocks at BAUD_DIV=4.
- Loopback to the existing receiver (BAUD_DIV=868): for 256 random bytes, the received byte equals the sent byte, and the line is high whenever tx_busy=0.
